memory_access: RTL

Memory stage of the five-stage RISC-V core. It sits directly downstream of `Execution` and consumes its EX/MEM outputs: the control bits, Rd, Zero, ALU result, branch target and store data. It holds the word-addressed data memory, resolves conditional branches back to fetch, and registers the MEM/WB pipeline boundary for write-back.

---
 rtl/riscv_pkg.sv | 26 ++
 rtl/memory_access_if.sv | 42 ++++
 rtl/data_mem.sv | 29 ++
 rtl/memory_access.sv | 93 +++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the RISC-V pipeline: datapath widths, the MEM/WB
// bundle and a small helper for load/store alignment.
package riscv_pkg;

    localparam int WORD_W     = 32;
    localparam int REG_ADDR_W = 5;

    // Everything the write-back stage needs from the memory stage
    typedef struct packed {
        logic                  memToReg;
        logic                  regWrite;
        logic [REG_ADDR_W-1:0] rd;
        logic [WORD_W-1:0]     aluResult;
        logic [WORD_W-1:0]     readData;
        logic                  misaligned;
    } memwb_t;

    // Only word accesses exist, so any memory access whose byte offset
    // is nonzero is misaligned
    function automatic logic isMisaligned(input logic memRead,
                                          input logic memWrite,
                                          input logic [1:0] byteOffset);
        return (memRead | memWrite) & (byteOffset != 2'b00);
    endfunction

endpackage

// File: rtl/memory_access_if.sv
// EX/MEM inputs and MEM/WB / branch outputs of the memory stage.
// The master side (execution stage or testbench) drives the *_in signals.
interface memory_access_if;
    import riscv_pkg::*;

    logic                  Ctl_MemtoReg_in;
    logic                  Ctl_RegWrite_in;
    logic                  Ctl_MemRead_in;
    logic                  Ctl_MemWrite_in;
    logic                  Ctl_Branch_in;
    logic [REG_ADDR_W-1:0] Rd_in;
    logic                  Zero_in;
    logic [WORD_W-1:0]     ALUresult_in;
    logic [WORD_W-1:0]     PCimm_in;
    logic [WORD_W-1:0]     ReadData2_in;

    logic                  PCSrc_out;
    logic [WORD_W-1:0]     PCimm_out;
    logic                  Ctl_MemtoReg_out;
    logic                  Ctl_RegWrite_out;
    logic [REG_ADDR_W-1:0] Rd_out;
    logic [WORD_W-1:0]     ALUresult_out;
    logic [WORD_W-1:0]     ReadData_out;
    logic                  Misaligned_out;

    modport master (
        output Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in,
               Ctl_MemWrite_in, Ctl_Branch_in, Rd_in, Zero_in,
               ALUresult_in, PCimm_in, ReadData2_in,
        input  PCSrc_out, PCimm_out, Ctl_MemtoReg_out, Ctl_RegWrite_out,
               Rd_out, ALUresult_out, ReadData_out, Misaligned_out
    );

    modport slave (
        input  Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in,
               Ctl_MemWrite_in, Ctl_Branch_in, Rd_in, Zero_in,
               ALUresult_in, PCimm_in, ReadData2_in,
        output PCSrc_out, PCimm_out, Ctl_MemtoReg_out, Ctl_RegWrite_out,
               Rd_out, ALUresult_out, ReadData_out, Misaligned_out
    );

endinterface

// File: rtl/data_mem.sv
// Single-port synchronous data RAM, 2^ADDR_W words, read-before-write.
// Contents are deliberately not reset; rdata returns 0 whenever re is low.
module data_mem
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] memQ [2**ADDR_W];
    logic [WORD_W-1:0] rdataQ;

    // Write and read in the same edge; the read sees the old word
    always_ff @(posedge clk) begin
        if (we) begin
            memQ[addr] <= wdata;
        end
        rdataQ <= re ? memQ[addr] : '0;
    end

    assign rdata = rdataQ;

endmodule

// File: rtl/memory_access.sv
// Memory stage: data RAM access, branch resolution toward fetch and the
// MEM/WB pipeline register feeding write-back.
module memory_access
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    memory_access_if.slave  bus
);

    logic [ADDR_W-1:0]              wordIndex;
    logic [WORD_W-ADDR_W-3:0]       unusedAddrBits;
    logic                           misaligned;
    logic                           memWe;
    logic                           memRe;
    logic [WORD_W-1:0]              memRdata;

    logic                           memToRegD, memToRegQ;
    logic                           regWriteD, regWriteQ;
    logic [REG_ADDR_W-1:0]          rdD, rdQ;
    logic [WORD_W-1:0]              aluResultD, aluResultQ;
    logic                           misalignedD, misalignedQ;
    memwb_t                         memWb;

    // Upper address bits wrap; only the word index reaches the RAM
    assign wordIndex      = bus.ALUresult_in[ADDR_W+1:2];
    assign unusedAddrBits = bus.ALUresult_in[WORD_W-1:ADDR_W+2];
    assign misaligned     = isMisaligned(bus.Ctl_MemRead_in, bus.Ctl_MemWrite_in,
                                         bus.ALUresult_in[1:0]);

    // Reset blocks stores and forces the registered read data to zero
    assign memWe = bus.Ctl_MemWrite_in & ~misaligned & ~rst;
    assign memRe = bus.Ctl_MemRead_in  & ~misaligned & ~rst;

    data_mem #(.ADDR_W(ADDR_W)) u_data_mem (
        .clk   (clk),
        .we    (memWe),
        .re    (memRe),
        .addr  (wordIndex),
        .wdata (bus.ReadData2_in),
        .rdata (memRdata)
    );

    // Branch decision and target go straight back to fetch
    assign bus.PCSrc_out = bus.Ctl_Branch_in & bus.Zero_in;
    assign bus.PCimm_out = bus.PCimm_in;

    // Next MEM/WB contents; a misaligned load must not write back garbage
    always_comb begin
        memToRegD   = bus.Ctl_MemtoReg_in;
        regWriteD   = bus.Ctl_RegWrite_in & ~(bus.Ctl_MemRead_in & misaligned);
        rdD         = bus.Rd_in;
        aluResultD  = bus.ALUresult_in;
        misalignedD = misaligned;
        if (rst) begin
            memToRegD   = 1'b0;
            regWriteD   = 1'b0;
            rdD         = '0;
            aluResultD  = '0;
            misalignedD = 1'b0;
        end
    end

    // MEM/WB register, captured every cycle since there is no stall
    always_ff @(posedge clk) begin
        memToRegQ   <= memToRegD;
        regWriteQ   <= regWriteD;
        rdQ         <= rdD;
        aluResultQ  <= aluResultD;
        misalignedQ <= misalignedD;
    end

    // Assemble the write-back bundle; load data comes registered from the RAM
    always_comb begin
        memWb            = '0;
        memWb.memToReg   = memToRegQ;
        memWb.regWrite   = regWriteQ;
        memWb.rd         = rdQ;
        memWb.aluResult  = aluResultQ;
        memWb.readData   = memRdata;
        memWb.misaligned = misalignedQ;
    end

    assign bus.Ctl_MemtoReg_out = memWb.memToReg;
    assign bus.Ctl_RegWrite_out = memWb.regWrite;
    assign bus.Rd_out           = memWb.rd;
    assign bus.ALUresult_out    = memWb.aluResult;
    assign bus.ReadData_out     = memWb.readData;
    assign bus.Misaligned_out   = memWb.misaligned;

endmodule
